piso_serializer_ctrl: RTL and testbench
=======================================

// Module: piso_serializer_ctrl
// PURPOSE
//   Sequences a WIDTH-bit parallel-in/serial-out shift register built from load/shift D flip-flops.
//   Accepts parallel words over a valid/ready handshake and drives the register's load and shift strobes.
//   Paces each bit for DIV clocks, counts bits, and flags frame start/end.
//   Sits between a word producer (e.g. a FIFO) and a serial line driver.
// PARAMETERS
//   WIDTH      8   bits per word (>=2)
//   DIV        4   clocks each serial bit is held (>=1)
//   MSB_FIRST  1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   reset        in   1      asynchronous, active-high; clears all state
//   in_data      in   WIDTH  parallel word; sampled on handshake edge
//   in_valid     in   1      producer has a word
//   in_ready     out  1      controller accepts a word this cycle
//   ser_out      out  1      serial bit (tail stage of shift register)
//   ser_valid    out  1      ser_out carries a frame bit
//   frame_start  out  1      1-cycle pulse: first cycle of bit 0 of a frame
//   frame_done   out  1      1-cycle pulse: last cycle of last bit of a frame
//   busy         out  1      frame in progress (state SHIFT)
//   piso_load    out  1      load strobe to shift register (observable)
//   piso_shift   out  1      shift strobe to shift register (observable)
// BEHAVIOUR
//   - Reset: state=IDLE, bit_cnt=0, div_cnt=0, shift register=0. Outputs: ser_out=0, ser_valid=0,
//     frame_start=0, frame_done=0, busy=0, piso_load=0, piso_shift=0, in_ready=1.
//   - Handshake: a word transfers on a rising edge where in_valid&&in_ready.
//     piso_load = in_valid&&in_ready (combinational), so the register loads on that same edge.
//     in_data is don't-care otherwise. in_valid may drop without a transfer.
//   - States:
//     IDLE:  in_ready=1. On transfer -> SHIFT with bit_cnt=WIDTH-1 and div_cnt=DIV-1.
//     SHIFT: ser_valid=1 and busy=1.
//       - div_cnt decrements each cycle.
//       - When div_cnt==0 and bit_cnt!=0: piso_shift=1, bit_cnt decrements, div_cnt reloads to DIV-1.
//       - When div_cnt==0 and bit_cnt==0: frame_done=1 and in_ready=1.
//         On transfer, stay in SHIFT, reload both counters; load has priority over shift.
//         With no transfer -> IDLE.
//   - Latency: handshake edge N -> bit 0 on ser_out from cycle N+1.
//     Frame lasts exactly WIDTH*DIV cycles. Back-to-back frames have zero idle cycles.
//   - frame_start is registered: high in the first cycle after any load edge.
//   - Bit order: when MSB_FIRST=0, in_data is bit-reversed before the register's parallel inputs.
//     The serial input of the first stage is tied to 0, so the register drains to 0.
//     ser_out=0 whenever ser_valid=0.
//   - DIV=1: shift every cycle; in_ready is high only in IDLE and in the last-bit cycle.
//   - Reset mid-frame: frame aborted immediately. No frame_done; outputs take reset values.
//   - Width rules: bit_cnt is $clog2(WIDTH) bits, div_cnt is $clog2(DIV)+1 bits. Both are down-counters, no wrap.
//   - piso_load and piso_shift are never both high.
// STRUCTURE
//   - Package piso_pkg: state enum {IDLE, SHIFT}; localparam function for counter widths.
//   - Sub-module piso_shift_reg #(WIDTH): chain of load/shift D flip-flops.
//     Ports: clk, reset, load, shift, d_par[WIDTH], q_ser. Hold when neither strobe is active.
//   - Controller holds the FSM, counters, handshake and pulse generation only.
// TESTING
//   1. Reset then idle -> in_ready=1; ser_valid, ser_out, busy, frame pulses all 0 for 20 cycles.
//   2. WIDTH=8, DIV=4, MSB_FIRST=1, send 8'hA5 ->
//      ser_out = 1,0,1,0,0,1,0,1, each held 4 cycles, 32 cycles total.
//      frame_start at cycle N+1, frame_done at cycle N+32.
//   3. Send 8'hA5 then 8'h3C with in_valid held high ->
//      second load on the frame_done cycle, no gap.
//      ser_valid stays high 64 cycles; exactly 2 frame_done pulses.
//   4. MSB_FIRST=0, DIV=1, send 8'h01 -> ser_out = 1,0,0,0,0,0,0,0 over 8 cycles.
//      in_ready=0 during cycles 1-7 of the frame.
//   5. Assert reset during bit 3 of a frame -> outputs return to reset values asynchronously.
//      No frame_done. A next word sent after release serializes correctly.
//   6. Random in_valid gaps, 200 words -> scoreboard matches words in order.
//      Assert load/shift are mutually exclusive and in_ready is never high mid-frame.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and counter-width helpers for the PISO serializer controller.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width);
  endfunction

  // One extra bit keeps DIV=1 legal (a 1-bit counter that only ever holds 0).
  function automatic int div_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Load/shift D flip-flop chain, tail stage drives q_ser; load wins over shift, zeros fill from the head.
// Zero latency to strobes: the register updates on the edge where load or shift is high, otherwise holds.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d_par,
  output logic             q_ser
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d_par;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign q_ser = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Valid/ready word intake and bit pacing for a PISO register: bit 0 appears the cycle after the load edge.
// Each bit is held DIV clocks; in_ready is high only when idle or in the final cycle of a frame.
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic             piso_load,
  output logic             piso_shift
);

  localparam int BW = bit_cnt_w(WIDTH);
  localparam int DW = div_cnt_w(DIV);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            frame_start_q;
  logic            div_zero, last_bit, xfer, q_ser;
  logic [WIDTH-1:0] d_par;

  always_comb begin
    d_par = in_data;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < WIDTH; i++) d_par[i] = in_data[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      frame_start_q <= xfer;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    div_zero   = (div_cnt_q == '0);
    last_bit   = (state_q == SHIFT) && div_zero && (bit_cnt_q == '0);
    in_ready   = (state_q == IDLE) || last_bit;
    xfer       = in_valid && in_ready;
    // A load in the last-bit cycle pre-empts the end of frame, so shift is never raised alongside it.
    piso_shift = (state_q == SHIFT) && div_zero && (bit_cnt_q != '0);
    piso_load  = xfer;

    if (xfer) begin
      state_d   = SHIFT;
      bit_cnt_d = BW'(WIDTH - 1);
      div_cnt_d = DW'(DIV - 1);
    end else if (state_q == SHIFT) begin
      if (!div_zero) begin
        div_cnt_d = div_cnt_q - DW'(1);
      end else if (bit_cnt_q != '0) begin
        bit_cnt_d = bit_cnt_q - BW'(1);
        div_cnt_d = DW'(DIV - 1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk  (clk),
    .reset(reset),
    .load (piso_load),
    .shift(piso_shift),
    .d_par(d_par),
    .q_ser(q_ser)
  );

  assign ser_valid   = (state_q == SHIFT);
  assign busy        = (state_q == SHIFT);
  assign ser_out     = q_ser & ser_valid;
  assign frame_done  = last_bit;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Two controller instances (DIV=4 MSB-first, DIV=1 LSB-first) checked with vector tables,
// hand-written corner sequences and a randomized run against a remaining-cycles frame model.
module tb_piso_serializer_ctrl;

  localparam int W  = 8;
  localparam int DA = 4;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0] a_data, b_data;
  logic a_valid, b_valid;
  logic a_rdy, a_so, a_sv, a_fs, a_fd, a_bsy, a_ld, a_sh;
  logic b_rdy, b_so, b_sv, b_fs, b_fd, b_bsy, b_ld, b_sh;

  typedef struct packed {
    logic rdy, so, sv, fs, fd, bsy, ld, sh;
  } outs_t;
  localparam logic [7:0] RST_OUTS = 8'h80;

  outs_t oa, ob;
  assign oa = {a_rdy, a_so, a_sv, a_fs, a_fd, a_bsy, a_ld, a_sh};
  assign ob = {b_rdy, b_so, b_sv, b_fs, b_fd, b_bsy, b_ld, b_sh};

  piso_serializer_ctrl #(.WIDTH(W), .DIV(DA), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
    .ser_out(a_so), .ser_valid(a_sv), .frame_start(a_fs), .frame_done(a_fd), .busy(a_bsy),
    .piso_load(a_ld), .piso_shift(a_sh)
  );

  piso_serializer_ctrl #(.WIDTH(W), .DIV(DB), .MSB_FIRST(0)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
    .ser_out(b_so), .ser_valid(b_sv), .frame_start(b_fs), .frame_done(b_fd), .busy(b_bsy),
    .piso_load(b_ld), .piso_shift(b_sh)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t get_o(input int sel);
    return (sel != 0) ? ob : oa;
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [W-1:0] d);
    if (sel != 0) begin
      b_valid = v; b_data = d;
    end else begin
      a_valid = v; a_data = d;
    end
  endtask

  // Entered and left on a falling edge; bits holds the expected serial order, bits[W-1] first.
  task automatic run_frame(input int sel, input logic [W-1:0] word, input logic [W-1:0] bits);
    int d;
    int fd;
    outs_t o;
    d  = (sel != 0) ? DB : DA;
    fd = W * d;
    set_in(sel, 1'b1, word);
    #1;
    o = get_o(sel);
    chk("tbl_load", o.ld, 1);
    chk("tbl_ready_idle", o.rdy, 1);
    @(negedge clk);
    set_in(sel, 1'b0, '0);
    for (int e = 0; e < fd; e++) begin
      #1;
      o = get_o(sel);
      chk("tbl_ser_out", o.so, bits[W-1-e/d]);
      chk("tbl_ser_valid", o.sv, 1);
      chk("tbl_busy", o.bsy, 1);
      chk("tbl_frame_start", o.fs, (e == 0));
      chk("tbl_frame_done", o.fd, (e == fd - 1));
      chk("tbl_ready", o.rdy, (e == fd - 1));
      chk("tbl_shift", o.sh, ((e % d) == d - 1) && ((e / d) != W - 1));
      @(negedge clk);
    end
    #1;
    chk("tbl_after_idle", get_o(sel), RST_OUTS);
    @(negedge clk);
  endtask

  task automatic run_random(input int sel, input int nwords);
    int d, fd, r, e, accepted, done, cyc;
    logic v, exp_rdy, exp_ld, msb;
    logic [W-1:0] dat, cur, got, exp_w;
    logic [W-1:0] sent[$];
    outs_t o;
    d = (sel != 0) ? DB : DA;
    fd = W * d;
    msb = (sel == 0);
    r = 0; accepted = 0; done = 0; cyc = 0; cur = '0; got = '0;
    while ((accepted < nwords || r > 0) && cyc < 30000) begin
      v   = (accepted < nwords) && ($urandom_range(0, 9) < 6);
      dat = W'($urandom);
      set_in(sel, v, dat);
      #1;
      o = get_o(sel);
      e = fd - r;
      exp_rdy = (r <= 1);
      exp_ld  = v && exp_rdy;
      chk("rnd_ready", o.rdy, exp_rdy);
      chk("rnd_load", o.ld, exp_ld);
      chk("rnd_ser_valid", o.sv, (r > 0));
      chk("rnd_busy", o.bsy, (r > 0));
      chk("rnd_frame_start", o.fs, (r == fd));
      chk("rnd_frame_done", o.fd, (r == 1));
      chk("rnd_shift", o.sh, (r > 0) && ((e % d) == d - 1) && ((e / d) != W - 1));
      chk("rnd_excl", o.ld & o.sh, 0);
      if (r > 0) begin
        chk("rnd_ser_out", o.so, msb ? cur[W-1-e/d] : cur[e/d]);
        if ((e % d) == 0) got = {got[W-2:0], o.so};
        if (r == 1) begin
          exp_w = sent.pop_front();
          chk("rnd_sb_word", got, msb ? exp_w : rev(exp_w));
          done++;
        end
      end else begin
        chk("rnd_ser_out_idle", o.so, 0);
      end
      if (exp_ld) begin
        r = fd; cur = dat; sent.push_back(dat); accepted++;
      end else if (r > 0) begin
        r--;
      end
      cyc++;
      @(negedge clk);
    end
    set_in(sel, 1'b0, '0);
    chk("rnd_timeout", (cyc < 30000), 1);
    chk("rnd_words_done", done, nwords);
  endtask

  typedef struct {
    int           sel;
    logic [W-1:0] word;
    logic [W-1:0] bits;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int sv_cnt, fd_cnt, k;
    logic [15:0] seq;

    tbl[0] = '{0, 8'hA5, 8'hA5};
    tbl[1] = '{0, 8'h3C, 8'h3C};
    tbl[2] = '{0, 8'h0F, 8'h0F};
    tbl[3] = '{1, 8'h01, 8'h80};
    tbl[4] = '{1, 8'h80, 8'h01};
    tbl[5] = '{1, 8'h0E, 8'h70};

    reset = 1'b1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_a", oa, RST_OUTS);
    chk("reset_b", ob, RST_OUTS);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("idle_a", oa, RST_OUTS);
      chk("idle_b", ob, RST_OUTS);
      @(negedge clk);
    end

    foreach (tbl[i]) run_frame(tbl[i].sel, tbl[i].word, tbl[i].bits);

    // Back-to-back: in_valid held, second word taken on the first frame_done cycle.
    seq = 16'hA53C;
    sv_cnt = 0;
    fd_cnt = 0;
    set_in(0, 1'b1, 8'hA5);
    for (int c = 0; c < 70; c++) begin
      #1;
      if (c >= 1 && c <= 64) begin
        k = (c - 1) / DA;
        chk("b2b_ser_out", oa.so, seq[15-k]);
      end
      sv_cnt += int'(oa.sv);
      fd_cnt += int'(oa.fd);
      if (c == 32) chk("b2b_load_on_done", {oa.fd, oa.ld, oa.sh}, 3'b110);
      @(negedge clk);
      if (c == 0) set_in(0, 1'b1, 8'h3C);
      else if (c == 32) set_in(0, 1'b0, '0);
    end
    chk("b2b_ser_valid_cycles", sv_cnt, 64);
    chk("b2b_frame_done_count", fd_cnt, 2);

    // Reset asserted between edges during bit 3, then a clean frame afterwards.
    set_in(0, 1'b1, 8'hA5);
    @(negedge clk);
    set_in(0, 1'b0, '0);
    repeat (3 * DA + 1) @(negedge clk);
    #1;
    chk("pre_rst_busy", oa.bsy, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_outs", oa, RST_OUTS);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_outs", oa, RST_OUTS);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_outs", oa, RST_OUTS);
    @(negedge clk);
    run_frame(0, 8'h5A, 8'h5A);

    run_random(0, 200);
    run_random(1, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
